// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO bus bundle: UART receive strobes in,
// Wishbone read data, acknowledge and status out.
interface uart_rx_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] rx_data_i;
    logic              rx_data_vld_i;
    logic              rx_parity_err_i;
    logic              rd_req_i;
    logic              clr_i;
    logic [31:0]       rd_data_o;
    logic              rd_ack_o;
    logic [CW-1:0]     count_o;
    logic              empty_o;
    logic              full_o;
    logic              overflow_o;
    logic              irq_o;

    modport master (
        output rx_data_i, rx_data_vld_i, rx_parity_err_i,
        output rd_req_i, clr_i,
        input  rd_data_o, rd_ack_o, count_o,
        input  empty_o, full_o, overflow_o, irq_o
    );

    modport slave (
        input  rx_data_i, rx_data_vld_i, rx_parity_err_i,
        input  rd_req_i, clr_i,
        output rd_data_o, rd_ack_o, count_o,
        output empty_o, full_o, overflow_o, irq_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: circular FIFO of {perr, data} entries with
// sticky overflow and a single-cycle acknowledged read port.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W:0] mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            ack_q, ack_d;
    logic [31:0]     rdata_q, rdata_d;

    logic full, empty, rd_acc, pop, push, drop;

    always_comb begin
        full   = (count_q == CW'(DEPTH));
        empty  = (count_q == '0);
        rd_acc = bus.rd_req_i & ~ack_q;
        pop    = rd_acc & ~empty & ~bus.clr_i;
        // a pop frees the slot, so a push into a full FIFO still lands
        push   = bus.rx_data_vld_i & (~full | pop) & ~bus.clr_i;
        drop   = bus.rx_data_vld_i & full & ~pop & ~bus.clr_i;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        ack_d   = rd_acc;
        rdata_d = rdata_q;

        if (rd_acc) begin
            rdata_d = '0;
            if (!bus.clr_i) begin
                rdata_d[9] = ovf_q;
                if (pop) begin
                    rdata_d[31]          = 1'b1;
                    rdata_d[8]           = mem_q[rptr_q][DATA_W];
                    rdata_d[DATA_W-1:0]  = mem_q[rptr_q][DATA_W-1:0];
                end
            end
        end

        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) ovf_d = 1'b1;

        if (bus.clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= {bus.rx_parity_err_i, bus.rx_data_i};
    end

    assign bus.rd_data_o  = rdata_q;
    assign bus.rd_ack_o   = ack_q;
    assign bus.count_o    = count_q;
    assign bus.empty_o    = empty;
    assign bus.full_o     = full;
    assign bus.overflow_o = ovf_q;
    assign bus.irq_o      = ~empty;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drives on falling edges,
// checks on falling edges against hand-computed values.
module tb_uart_rx_fifo;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   vecs   = 0;
    int   errs   = 0;
    logic [31:0] w;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus_if ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus_if.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        @(negedge clk_i);
        bus_if.rx_data_i       = d;
        bus_if.rx_parity_err_i = p;
        bus_if.rx_data_vld_i   = 1'b1;
        @(negedge clk_i);
        bus_if.rx_data_vld_i   = 1'b0;
        bus_if.rx_parity_err_i = 1'b0;
    endtask

    task automatic rd(output logic [31:0] d);
        @(negedge clk_i);
        bus_if.rd_req_i = 1'b1;
        @(negedge clk_i);
        bus_if.rd_req_i = 1'b0;
        chk("rd_ack", 32'(bus_if.rd_ack_o), 32'd1);
        d = bus_if.rd_data_o;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, 32'(bus_if.count_o), 32'd0);
        chk({tag, "_empty"}, 32'(bus_if.empty_o), 32'd1);
        chk({tag, "_full"},  32'(bus_if.full_o), 32'd0);
        chk({tag, "_ovf"},   32'(bus_if.overflow_o), 32'd0);
        chk({tag, "_irq"},   32'(bus_if.irq_o), 32'd0);
        chk({tag, "_ack"},   32'(bus_if.rd_ack_o), 32'd0);
        chk({tag, "_data"},  bus_if.rd_data_o, 32'h0);
    endtask

    initial begin
        bus_if.rx_data_i       = '0;
        bus_if.rx_data_vld_i   = 1'b0;
        bus_if.rx_parity_err_i = 1'b0;
        bus_if.rd_req_i        = 1'b0;
        bus_if.clr_i           = 1'b0;
        #12;
        chk_reset("reset");
        rst_ni = 1'b1;

        // basic order
        push(8'h41, 1'b0);
        push(8'h42, 1'b0);
        push(8'h43, 1'b0);
        chk("cnt3", 32'(bus_if.count_o), 32'd3);
        chk("irq3", 32'(bus_if.irq_o), 32'd1);
        rd(w); chk("rd41", w, 32'h8000_0041);
        rd(w); chk("rd42", w, 32'h8000_0042);
        rd(w); chk("rd43", w, 32'h8000_0043);
        chk("empty3", 32'(bus_if.empty_o), 32'd1);

        // parity flag
        push(8'h55, 1'b1);
        rd(w); chk("rd_perr", w, 32'h8000_0155);

        // overflow
        for (int i = 0; i < DEPTH + 2; i++) push(8'(i), 1'b0);
        chk("ovf_full", 32'(bus_if.full_o), 32'd1);
        chk("ovf_flag", 32'(bus_if.overflow_o), 32'd1);
        chk("ovf_cnt", 32'(bus_if.count_o), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            rd(w);
            chk($sformatf("ovf_rd%0d", i), w, 32'h8000_0200 | 32'(i));
        end
        rd(w); chk("ovf_empty_rd", w, 32'h0000_0200);
        @(negedge clk_i); bus_if.clr_i = 1'b1;
        @(negedge clk_i); bus_if.clr_i = 1'b0;
        chk("clr_ovf", 32'(bus_if.overflow_o), 32'd0);

        // held request: ack every other cycle
        push(8'hA0, 1'b0);
        push(8'hA1, 1'b0);
        @(negedge clk_i); bus_if.rd_req_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            chk($sformatf("hold_ack%0d", i), 32'(bus_if.rd_ack_o),
                32'(i % 2 == 0));
            if (i == 0) chk("hold_d0", bus_if.rd_data_o, 32'h8000_00A0);
            if (i == 2) chk("hold_d1", bus_if.rd_data_o, 32'h8000_00A1);
            if (i == 4) chk("hold_d2", bus_if.rd_data_o, 32'h0);
        end
        bus_if.rd_req_i = 1'b0;

        // full, simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i), 1'b0);
        chk("pp_full", 32'(bus_if.full_o), 32'd1);
        @(negedge clk_i);
        bus_if.rx_data_i     = 8'h99;
        bus_if.rx_data_vld_i = 1'b1;
        bus_if.rd_req_i      = 1'b1;
        @(negedge clk_i);
        bus_if.rx_data_vld_i = 1'b0;
        bus_if.rd_req_i      = 1'b0;
        chk("pp_ack", 32'(bus_if.rd_ack_o), 32'd1);
        chk("pp_data", bus_if.rd_data_o, 32'h8000_0010);
        chk("pp_cnt", 32'(bus_if.count_o), 32'd16);
        chk("pp_ovf", 32'(bus_if.overflow_o), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            rd(w);
            chk($sformatf("pp_rd%0d", i), w, 32'h8000_0010 + 32'(i));
        end
        rd(w); chk("pp_last", w, 32'h8000_0099);
        chk("pp_empty", 32'(bus_if.empty_o), 32'd1);

        // clear with 5 entries, overflow set, push in same cycle
        for (int i = 0; i < DEPTH + 1; i++) push(8'h60 + 8'(i), 1'b0);
        for (int i = 0; i < DEPTH - 5; i++) rd(w);
        chk("clr_pre_cnt", 32'(bus_if.count_o), 32'd5);
        chk("clr_pre_ovf", 32'(bus_if.overflow_o), 32'd1);
        @(negedge clk_i);
        bus_if.clr_i         = 1'b1;
        bus_if.rx_data_i     = 8'h77;
        bus_if.rx_data_vld_i = 1'b1;
        @(negedge clk_i);
        bus_if.clr_i         = 1'b0;
        bus_if.rx_data_vld_i = 1'b0;
        chk("clr_cnt", 32'(bus_if.count_o), 32'd0);
        chk("clr_ovf2", 32'(bus_if.overflow_o), 32'd0);
        chk("clr_empty", 32'(bus_if.empty_o), 32'd1);
        rd(w); chk("clr_rd", w, 32'h0);

        // read accepted together with clear
        push(8'h33, 1'b1);
        @(negedge clk_i);
        bus_if.clr_i    = 1'b1;
        bus_if.rd_req_i = 1'b1;
        @(negedge clk_i);
        bus_if.clr_i    = 1'b0;
        bus_if.rd_req_i = 1'b0;
        chk("clrrd_ack", 32'(bus_if.rd_ack_o), 32'd1);
        chk("clrrd_data", bus_if.rd_data_o, 32'h0);
        chk("clrrd_cnt", 32'(bus_if.count_o), 32'd0);

        // asynchronous reset mid-stream
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h03, 1'b0);
        @(negedge clk_i); bus_if.rd_req_i = 1'b1;
        @(posedge clk_i); #2;
        bus_if.rd_req_i = 1'b0;
        chk("mid_ack_pre", 32'(bus_if.rd_ack_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk_i); rst_ni = 1'b1;
        push(8'h5A, 1'b0);
        chk("post_cnt", 32'(bus_if.count_o), 32'd1);
        rd(w); chk("post_rd", w, 32'h8000_005A);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
